// File: rtl/timer_multi_pkg.sv
// Shared constants and helpers for the multi-channel timer.
package timer_multi_pkg;

  localparam int unsigned MAX_CHANNELS = 16;

  localparam logic RST_FLAG = 1'b0;

  typedef logic [$clog2(MAX_CHANNELS+1)-1:0] chan_cnt_t;

  function automatic int unsigned slice_lo(
    input int unsigned ch,
    input int unsigned width
  );
    return ch * width;
  endfunction

endpackage

// File: rtl/timer_multi_channel.sv
// One timer channel: counter, one-shot done flag, sticky interrupt
// and registered running status.
module timer_multi_channel
  import timer_multi_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] terminal,
  input  logic             enable,
  input  logic             periodic,
  input  logic             clear,
  output logic             interrupt,
  output logic             running
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             interrupt_q, interrupt_d;
  logic             running_q, running_d;
  logic             expire;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      done_q      <= RST_FLAG;
      interrupt_q <= RST_FLAG;
      running_q   <= RST_FLAG;
    end else begin
      count_q     <= count_d;
      done_q      <= done_d;
      interrupt_q <= interrupt_d;
      running_q   <= running_d;
    end
  end

  // >= lets a lowered terminal expire on the next tick instead of wrapping
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    expire  = 1'b0;
    if (!enable) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (!done_q && tick) begin
      if (count_q >= terminal) begin
        expire = 1'b1;
        if (periodic) begin
          count_d = '0;
        end else begin
          done_d = 1'b1;
        end
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_comb begin
    interrupt_d = expire | (interrupt_q & ~clear);
    running_d   = enable & ~done_d;
  end

  assign interrupt = interrupt_q;
  assign running   = running_q;

endmodule

// File: rtl/timer_multi.sv
// Multi-channel timer: shared prescaler feeding CHANNELS independent
// one-shot/periodic counters with sticky interrupts.
module timer_multi
  import timer_multi_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int CHANNELS       = 4,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [CHANNELS*WIDTH-1:0] timer_count,
  input  logic [CHANNELS-1:0]       timer_enable,
  input  logic [CHANNELS-1:0]       timer_periodic,
  input  logic [CHANNELS-1:0]       timer_interrupt_clear,
  output logic [CHANNELS-1:0]       timer_interrupt,
  output logic [CHANNELS-1:0]       timer_running,
  output logic                      timer_irq
);

  if (CHANNELS < 1 || CHANNELS > int'(MAX_CHANNELS)) begin : g_bad_channels
    $error("timer_multi: CHANNELS out of range");
  end

  logic [PRESCALE_WIDTH-1:0] pcount_q, pcount_d;
  logic                      any_en;
  logic                      tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcount_q <= '0;
    end else begin
      pcount_q <= pcount_d;
    end
  end

  // Held at zero while idle so the first tick after enabling is fixed
  always_comb begin
    any_en   = |timer_enable;
    tick     = (pcount_q == prescale);
    pcount_d = '0;
    if (any_en && !tick) begin
      pcount_d = pcount_q + PRESCALE_WIDTH'(1);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    timer_multi_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .terminal  (timer_count[slice_lo(i, WIDTH) +: WIDTH]),
      .enable    (timer_enable[i]),
      .periodic  (timer_periodic[i]),
      .clear     (timer_interrupt_clear[i]),
      .interrupt (timer_interrupt[i]),
      .running   (timer_running[i])
    );
  end

  assign timer_irq = |timer_interrupt;

endmodule

// File: tb/tb_timer_multi.sv
// Directed and random stimulus for timer_multi, checked against a
// per-tick behavioural model of the channels.
module tb_timer_multi;

  localparam int W  = 32;
  localparam int CH = 4;
  localparam int PW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [PW-1:0]   prescale;
  logic [CH*W-1:0] timer_count;
  logic [CH-1:0]   timer_enable;
  logic [CH-1:0]   timer_periodic;
  logic [CH-1:0]   timer_interrupt_clear;
  logic [CH-1:0]   timer_interrupt;
  logic [CH-1:0]   timer_running;
  logic            timer_irq;

  int checks = 0;
  int errors = 0;

  int unsigned m_pc;
  int unsigned m_cnt [CH];
  bit          m_done [CH];
  bit [CH-1:0] m_int;
  bit [CH-1:0] m_run;

  always #5 clk = ~clk;

  timer_multi #(
    .WIDTH          (W),
    .CHANNELS       (CH),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .prescale              (prescale),
    .timer_count           (timer_count),
    .timer_enable          (timer_enable),
    .timer_periodic        (timer_periodic),
    .timer_interrupt_clear (timer_interrupt_clear),
    .timer_interrupt       (timer_interrupt),
    .timer_running         (timer_running),
    .timer_irq             (timer_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned term(input int c);
    return timer_count[c*W +: W];
  endfunction

  task automatic set_term(input int c, input int unsigned v);
    timer_count[c*W +: W] = v;
  endtask

  // Advance the model by one edge using the inputs now applied
  task automatic model_edge();
    bit tk;
    bit ex;
    tk = (m_pc == prescale);
    if (reset) begin
      m_pc  = 0;
      m_int = '0;
      m_run = '0;
      for (int c = 0; c < CH; c++) begin
        m_cnt[c]  = 0;
        m_done[c] = 0;
      end
      return;
    end
    if (timer_enable == '0 || tk) m_pc = 0;
    else m_pc = (m_pc + 1) % (1 << PW);
    for (int c = 0; c < CH; c++) begin
      ex = 0;
      if (!timer_enable[c]) begin
        m_cnt[c]  = 0;
        m_done[c] = 0;
      end else if (!m_done[c] && tk) begin
        if (m_cnt[c] >= term(c)) begin
          ex = 1;
          if (timer_periodic[c]) m_cnt[c] = 0;
          else m_done[c] = 1;
        end else begin
          m_cnt[c]++;
        end
      end
      m_int[c] = ex | (m_int[c] & ~timer_interrupt_clear[c]);
      m_run[c] = timer_enable[c] & ~m_done[c];
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("interrupt", 32'(timer_interrupt), 32'(m_int));
    chk("running", 32'(timer_running), 32'(m_run));
    chk("irq", 32'(timer_irq), 32'(|m_int));
  endtask

  task automatic wait_rise(input int c, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      step();
      if (timer_interrupt[c]) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int h0;
    int h1;
    int first1;
    reset                 = 1'b1;
    prescale              = '0;
    timer_count           = '0;
    timer_enable          = '0;
    timer_periodic        = '0;
    timer_interrupt_clear = '0;
    m_pc = 0;
    m_int = '0;
    m_run = '0;
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0;
      m_done[c] = 0;
    end
    @(negedge clk);
    step();
    step();
    chk("reset_int", 32'(timer_interrupt), 0);
    chk("reset_run", 32'(timer_running), 0);
    reset = 1'b0;

    // periodic, prescale 0
    set_term(0, 3);
    timer_periodic = 4'b0001;
    timer_enable   = 4'b0001;
    wait_rise(0, 20, n);
    chk("per_first", 32'(n), 4);
    timer_interrupt_clear = 4'b0001;
    step();
    chk("per_clr", 32'(timer_interrupt[0]), 0);
    timer_interrupt_clear = '0;
    wait_rise(0, 20, n);
    chk("per_again", 32'(n), 3);

    // reset mid-count
    timer_enable = '0;
    timer_interrupt_clear = 4'b1111;
    step();
    timer_interrupt_clear = '0;
    set_term(0, 10);
    timer_enable = 4'b0001;
    repeat (5) step();
    reset = 1'b1;
    step();
    chk("rst_mid_int", 32'(timer_interrupt), 0);
    chk("rst_mid_run", 32'(timer_running), 0);
    chk("rst_mid_irq", 32'(timer_irq), 0);
    reset = 1'b0;
    wait_rise(0, 30, n);
    chk("rst_reenable", 32'(n), 11);

    // one-shot, prescale 4
    timer_enable = '0;
    step();
    prescale = 8'd4;
    set_term(1, 2);
    timer_enable = 4'b0010;
    wait_rise(1, 40, n);
    chk("oneshot_lat", 32'(n), 15);
    chk("oneshot_run", 32'(timer_running[1]), 0);
    timer_interrupt_clear = 4'b0010;
    step();
    timer_interrupt_clear = '0;
    repeat (30) step();
    chk("oneshot_quiet", 32'(timer_interrupt[1]), 0);
    timer_enable = '0;
    step();
    timer_enable = 4'b0010;
    wait_rise(1, 40, n);
    chk("oneshot_restart", 32'(n), 15);

    // simultaneous set and clear
    timer_enable = '0;
    step();
    prescale = '0;
    set_term(2, 1);
    timer_periodic = '0;
    timer_interrupt_clear = 4'b0100;
    timer_enable = 4'b0100;
    wait_rise(2, 10, n);
    chk("setclr_lat", 32'(n), 2);
    timer_interrupt_clear = '0;
    step();
    chk("setclr_hold", 32'(timer_interrupt[2]), 1);
    timer_interrupt_clear = 4'b0100;
    step();
    chk("setclr_drop", 32'(timer_interrupt[2]), 0);
    timer_interrupt_clear = '0;

    // terminal lowered below count
    timer_enable = '0;
    step();
    set_term(3, 100);
    timer_periodic = 4'b1000;
    timer_enable = 4'b1000;
    repeat (50) step();
    chk("lower_pre", 32'(timer_interrupt[3]), 0);
    set_term(3, 20);
    step();
    chk("lower_exp", 32'(timer_interrupt[3]), 1);
    timer_interrupt_clear = 4'b1000;
    step();
    timer_interrupt_clear = '0;
    wait_rise(3, 40, n);
    chk("lower_reload", 32'(n), 20);

    // terminal 0 and channel independence
    timer_enable = '0;
    step();
    prescale = 8'd1;
    set_term(0, 0);
    set_term(1, 5);
    timer_periodic = 4'b0011;
    timer_interrupt_clear = 4'b1111;
    timer_enable = 4'b0011;
    h0 = 0;
    h1 = 0;
    first1 = -1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (timer_interrupt[0]) h0++;
      if (timer_interrupt[1]) begin
        h1++;
        if (first1 < 0) first1 = k;
      end
    end
    chk("indep_ch0", 32'(h0), 12);
    chk("indep_ch1", 32'(h1), 2);
    chk("indep_first1", 32'(first1), 12);
    timer_interrupt_clear = '0;

    // random
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) timer_enable = CH'($urandom);
      if ($urandom_range(0, 15) == 0) timer_periodic = CH'($urandom);
      if (timer_enable == '0 && $urandom_range(0, 3) == 0)
        prescale = PW'($urandom_range(0, 3));
      for (int c = 0; c < CH; c++) begin
        timer_interrupt_clear[c] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 31) == 0) set_term(c, $urandom_range(0, 6));
      end
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
